// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-serial memory controller:
// FSM states, requester ownership, IO-region decode and access-size codes.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_t;

    localparam logic [1:0] IO_REGION = 2'b11;
    localparam int         IO_LSB    = 16;

    localparam int         IDX_W     = 3;
    localparam logic [2:0] SIZE_BYTE = 3'd1;
    localparam logic [2:0] SIZE_HALF = 3'd2;
    localparam logic [2:0] SIZE_WORD = 3'd4;

    // IO space is strictly one byte per access so a device register is touched only once.
    function automatic logic [2:0] size_to_len(input logic [2:0] size, input logic is_io);
        logic [2:0] len;
        len = SIZE_WORD;
        if (is_io) begin
            len = SIZE_BYTE;
        end else begin
            case (size)
                SIZE_BYTE: len = SIZE_BYTE;
                SIZE_HALF: len = SIZE_HALF;
                default:   len = SIZE_WORD;
            endcase
        end
        return len;
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// CPU request/response ports and external byte bus bundled together;
// master = CPU core plus RAM side, slave = the controller.
interface mem_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_flush;
    logic              if_done;
    logic [DATA_W-1:0] if_data;

    logic              ls_req;
    logic              ls_wr;
    logic [ADDR_W-1:0] ls_addr;
    logic [2:0]        ls_size;
    logic [DATA_W-1:0] ls_wdata;
    logic              ls_done;
    logic [DATA_W-1:0] ls_rdata;

    logic [7:0]        mem_din;
    logic [7:0]        mem_dout;
    logic [ADDR_W-1:0] mem_a;
    logic              mem_wr;

    modport master (
        output if_req, if_addr, if_flush,
        input  if_done, if_data,
        output ls_req, ls_wr, ls_addr, ls_size, ls_wdata,
        input  ls_done, ls_rdata,
        output mem_din,
        input  mem_dout, mem_a, mem_wr
    );

    modport slave (
        input  if_req, if_addr, if_flush,
        output if_done, if_data,
        input  ls_req, ls_wr, ls_addr, ls_size, ls_wdata,
        output ls_done, ls_rdata,
        input  mem_din,
        output mem_dout, mem_a, mem_wr
    );
endinterface

// File: rtl/mem_ctrl_byte_assembler.sv
// Word register with separate issue and capture byte indices: gathers read
// bytes little-endian, or selects store bytes; issue can roll back to capture.
module mem_ctrl_byte_assembler
    import mem_ctrl_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic [DATA_W-1:0] i_init,
    input  logic              i_issue,
    input  logic              i_capture,
    input  logic              i_store,
    input  logic [7:0]        i_byte,
    input  logic              i_rollback,
    output logic [DATA_W-1:0] o_data,
    output logic [IDX_W-1:0]  o_issue_idx,
    output logic [IDX_W-1:0]  o_cap_idx,
    output logic [7:0]        o_sel_byte
);
    localparam int NBYTES = DATA_W / 8;
    localparam int LANE_W = $clog2(NBYTES);

    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] w_data_next;
    logic [IDX_W-1:0]  r_issue;
    logic [IDX_W-1:0]  r_cap;
    logic [7:0]        w_lane [NBYTES];
    logic [LANE_W-1:0] w_sel;

    genvar gi;
    generate
        for (gi = 0; gi < NBYTES; gi++) begin : g_lane
            assign w_lane[gi] = r_data[gi*8 +: 8];
            assign w_data_next[gi*8 +: 8] =
                i_clear                                            ? i_init[gi*8 +: 8] :
                (i_capture && i_store && (r_cap == IDX_W'(gi)))    ? i_byte            :
                                                                     r_data[gi*8 +: 8];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data  <= '0;
            r_issue <= '0;
            r_cap   <= '0;
        end else begin
            r_data <= w_data_next;
            if (i_clear) begin
                r_issue <= '0;
                r_cap   <= '0;
            end else if (i_rollback) begin
                r_issue <= r_cap;
            end else begin
                if (i_issue)   r_issue <= r_issue + IDX_W'(1);
                if (i_capture) r_cap   <= r_cap + IDX_W'(1);
            end
        end
    end

    assign w_sel       = r_issue[LANE_W-1:0];
    assign o_sel_byte  = (r_issue < IDX_W'(NBYTES)) ? w_lane[w_sel] : 8'h00;
    assign o_data      = r_data;
    assign o_issue_idx = r_issue;
    assign o_cap_idx   = r_cap;

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates fetch and load/store requests
// and drives the external 8-bit bus one byte per cycle.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     rdy,
    mem_ctrl_if.slave bus
);
    state_t            r_state;
    state_t            w_state_next;
    owner_t            r_owner;
    owner_t            w_owner_next;
    logic [ADDR_W-1:0] r_base;
    logic [IDX_W-1:0]  r_len;
    logic [ADDR_W-1:0] r_mem_a;

    logic [DATA_W-1:0] w_data;
    logic [IDX_W-1:0]  w_issue;
    logic [IDX_W-1:0]  w_cap;
    logic [7:0]        w_sel_byte;
    logic [ADDR_W-1:0] w_mem_a;
    logic [DATA_W-1:0] w_init;

    logic w_busy;
    logic w_presenting;
    logic w_capture;
    logic w_issue_adv;
    logic w_rollback;
    logic w_accept_ls;
    logic w_accept_if;
    logic w_clear;
    logic w_ls_io;
    logic w_last_cap;
    logic w_last_issue;

    assign w_busy       = (r_state == ST_RD) || (r_state == ST_WR);
    assign w_presenting = w_busy && (w_issue < r_len);
    assign w_mem_a      = w_presenting ? (r_base + {{(ADDR_W-IDX_W){1'b0}}, w_issue}) : r_mem_a;

    // mem_din carries the byte addressed one cycle earlier, so capture trails issue by one.
    assign w_capture    = rdy && (r_state == ST_RD) && (w_cap < w_issue);
    assign w_issue_adv  = rdy && w_presenting;
    // A read byte in flight during a pause is lost; re-issue it after resuming.
    assign w_rollback   = !rdy && (r_state == ST_RD);

    assign w_accept_ls  = rdy && (r_state == ST_IDLE) && bus.ls_req;
    assign w_accept_if  = rdy && (r_state == ST_IDLE) && !bus.ls_req && bus.if_req && !bus.if_flush;
    assign w_clear      = w_accept_ls || w_accept_if;
    assign w_init       = (w_accept_ls && bus.ls_wr) ? bus.ls_wdata : '0;
    assign w_ls_io      = (bus.ls_addr[IO_LSB+1:IO_LSB] == IO_REGION);

    assign w_last_cap   = (w_cap == (r_len - IDX_W'(1)));
    assign w_last_issue = (w_issue == (r_len - IDX_W'(1)));

    mem_ctrl_byte_assembler #(.DATA_W(DATA_W)) u_asm (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (w_clear),
        .i_init      (w_init),
        .i_issue     (w_issue_adv),
        .i_capture   (w_capture || ((r_state == ST_WR) && w_issue_adv)),
        .i_store     (r_state == ST_RD),
        .i_byte      (bus.mem_din),
        .i_rollback  (w_rollback),
        .o_data      (w_data),
        .o_issue_idx (w_issue),
        .o_cap_idx   (w_cap),
        .o_sel_byte  (w_sel_byte)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_owner <= OWN_IF;
            r_base  <= '0;
            r_len   <= '0;
            r_mem_a <= '0;
        end else begin
            r_state <= w_state_next;
            r_owner <= w_owner_next;
            if (w_clear) begin
                r_base <= w_accept_ls ? bus.ls_addr : bus.if_addr;
                r_len  <= w_accept_ls ? size_to_len(bus.ls_size, w_ls_io) : SIZE_WORD;
            end
            if (rdy) r_mem_a <= w_mem_a;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_owner_next = r_owner;
        if (rdy) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept_ls) begin
                        w_state_next = bus.ls_wr ? ST_WR : ST_RD;
                        w_owner_next = OWN_LS;
                    end else if (w_accept_if) begin
                        w_state_next = ST_RD;
                        w_owner_next = OWN_IF;
                    end
                end
                ST_RD: begin
                    if ((r_owner == OWN_IF) && bus.if_flush) w_state_next = ST_IDLE;
                    else if (w_capture && w_last_cap)        w_state_next = ST_DONE;
                end
                ST_WR: begin
                    if (w_last_issue) w_state_next = ST_DONE;
                end
                ST_DONE: w_state_next = ST_IDLE;
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    assign bus.mem_a    = w_mem_a;
    assign bus.mem_wr   = (r_state == ST_WR) && w_presenting && rdy;
    assign bus.mem_dout = ((r_state == ST_WR) && w_presenting) ? w_sel_byte : 8'h00;

    assign bus.if_done  = (r_state == ST_DONE) && (r_owner == OWN_IF) && !bus.if_flush;
    assign bus.if_data  = ((r_state == ST_DONE) && (r_owner == OWN_IF)) ? w_data : '0;
    assign bus.ls_done  = (r_state == ST_DONE) && (r_owner == OWN_LS);
    assign bus.ls_rdata = ((r_state == ST_DONE) && (r_owner == OWN_LS)) ? w_data : '0;

endmodule
